// File: rtl/cnn_pkg.sv
// Shared types and elaboration helpers for the CNN feature-collection blocks.
package cnn_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    STREAM  = 1'b1
  } state_t;

  function automatic int out_pixels(input int image_width, input int stride);
    return (image_width / stride) * (image_width / stride);
  endfunction

  // Kernels are statically bound to a shared lane in round-robin order.
  function automatic int lane_of(input int k, input int pe);
    return k % pe;
  endfunction

endpackage

// File: rtl/feature_map_bank.sv
// One kernel's pooled feature map: sequential write with a saturating counter,
// asynchronous read by pixel index.
module feature_map_bank
  import cnn_pkg::*;
#(
  parameter int BitSize   = 32,
  parameter int OutPixels = 4,
  parameter int AddrWidth = (OutPixels > 1) ? $clog2(OutPixels) : 1
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic                 clear,
  input  logic                 wr_en,
  input  logic [BitSize-1:0]   wr_data,
  input  logic [AddrWidth-1:0] rd_addr,
  output logic [BitSize-1:0]   rd_data,
  output logic                 full
);

  localparam int CntWidth = $clog2(OutPixels + 1);

  logic [CntWidth-1:0] wcnt;
  logic [BitSize-1:0]  mem [OutPixels];

  assign full    = (wcnt == CntWidth'(OutPixels));
  assign rd_data = mem[rd_addr];

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wcnt <= '0;
    end else if (clear) begin
      wcnt <= '0;
    end else if (wr_en && !full) begin
      wcnt <= wcnt + 1'b1;
    end
  end

  // Storage is deliberately left out of reset; the counter alone defines validity.
  always_ff @(posedge clk) begin
    if (wr_en && !full) begin
      mem[wcnt[AddrWidth-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/pooled_feature_collector.sv
// Gathers pooled pixels of all kernels from shared lanes into per-kernel banks,
// then streams the flattened maps (kernel-major) under valid/ready.
module pooled_feature_collector
  import cnn_pkg::*;
#(
  parameter int BitSize            = 32,
  parameter int ImageWidth         = 4,
  parameter int Stride             = 2,
  parameter int NumberOfK          = 4,
  parameter int ProcessingElements = 2
) (
  input  logic                                  clk,
  input  logic                                  res_n,
  input  logic [NumberOfK-1:0]                  in_valid,
  input  logic [ProcessingElements*BitSize-1:0] in_data,
  output logic                                  in_ready,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [BitSize-1:0]                    out_data,
  output logic                                  out_last,
  output logic                                  out_done,
  output logic                                  err
);

  localparam int OutPixels = out_pixels(ImageWidth, Stride);
  localparam int Total     = NumberOfK * OutPixels;
  localparam int AddrWidth = (OutPixels > 1) ? $clog2(OutPixels) : 1;
  localparam int PtrWidth  = (Total > 1) ? $clog2(Total) : 1;
  localparam logic [PtrWidth-1:0] LastIdx = PtrWidth'(Total - 1);

  state_t                state;
  logic [PtrWidth-1:0]   rptr;
  logic [PtrWidth-1:0]   next_ptr;
  logic [NumberOfK-1:0]  grant;
  logic [NumberOfK-1:0]  wr_en;
  logic [NumberOfK-1:0]  full;
  logic                  conflict;
  logic                  overflow;
  logic                  all_full;
  logic                  fire;
  logic                  frame_end;
  logic                  err_event;
  logic [AddrWidth-1:0]  rd_addr;
  logic [BitSize-1:0]    rd_data [NumberOfK];
  logic [BitSize-1:0]    next_word;

  // A kernel loses its lane whenever a lower-numbered kernel on the same lane is also valid.
  always_comb begin
    grant    = '0;
    conflict = 1'b0;
    for (int k = 0; k < NumberOfK; k++) begin
      grant[k] = in_valid[k];
      for (int j = 0; j < k; j++) begin
        if (in_valid[j] && (lane_of(j, ProcessingElements) == lane_of(k, ProcessingElements))) begin
          grant[k] = 1'b0;
        end
      end
      if (in_valid[k] && !grant[k]) begin
        conflict = 1'b1;
      end
    end
  end

  assign overflow  = |(in_valid & full);
  assign all_full  = &full;
  assign in_ready  = (state == COLLECT);
  assign wr_en     = {NumberOfK{state == COLLECT}} & grant & ~full;
  assign fire      = out_valid & out_ready;
  assign frame_end = (state == STREAM) & fire & out_last;
  assign err_event = (state == COLLECT) ? (conflict | overflow) : (|in_valid);

  for (genvar k = 0; k < NumberOfK; k++) begin : g_bank
    feature_map_bank #(
      .BitSize   (BitSize),
      .OutPixels (OutPixels)
    ) u_bank (
      .clk     (clk),
      .res_n   (res_n),
      .clear   (frame_end),
      .wr_en   (wr_en[k]),
      .wr_data (in_data[lane_of(k, ProcessingElements)*BitSize +: BitSize]),
      .rd_addr (rd_addr),
      .rd_data (rd_data[k]),
      .full    (full[k])
    );
  end

  // Look one word ahead so the output register refills on the accepting edge.
  always_comb begin
    next_ptr  = (state == COLLECT) ? '0 : rptr + 1'b1;
    rd_addr   = AddrWidth'(int'(next_ptr) % OutPixels);
    next_word = '0;
    for (int k = 0; k < NumberOfK; k++) begin
      if (int'(next_ptr) / OutPixels == k) begin
        next_word = rd_data[k];
      end
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state     <= COLLECT;
      rptr      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_done  <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_done <= 1'b0;
      if (err_event) begin
        err <= 1'b1;
      end
      case (state)
        COLLECT: begin
          if (all_full) begin
            state     <= STREAM;
            out_valid <= 1'b1;
            out_data  <= next_word;
            rptr      <= '0;
            out_last  <= (LastIdx == '0);
          end
        end
        STREAM: begin
          if (fire) begin
            if (out_last) begin
              state     <= COLLECT;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_done  <= 1'b1;
              rptr      <= '0;
            end else begin
              rptr     <= next_ptr;
              out_data <= next_word;
              out_last <= (next_ptr == LastIdx);
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_pooled_feature_collector.sv
// Scoreboard bench: stimulus pushes expected stream words, a negedge monitor pops and compares.
module tb_pooled_feature_collector;
  import cnn_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic [3:0]  in_valid = '0;
  logic [63:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_done;
  logic        err;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          accepted = 0;
  int          done_count = 0;
  int          rdy_mode = 0;
  logic        expect_done = 1'b0;
  logic        held = 1'b0;
  logic [31:0] held_data = '0;
  logic        held_last = 1'b0;

  always #5 clk = ~clk;

  pooled_feature_collector #(
    .BitSize(32), .ImageWidth(4), .Stride(2), .NumberOfK(4), .ProcessingElements(2)
  ) dut (
    .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_done(out_done), .err(err)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: pop on every accepted word, track stalls and the done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!res_n) begin
        expect_done = 1'b0;
        held = 1'b0;
      end else begin
        if (expect_done) begin
          check_output("done_pulse", 32'(out_done), 32'd1);
          check_output("valid_after_last", 32'(out_valid), 32'd0);
          expect_done = 1'b0;
          done_count++;
        end else if (out_done) begin
          check_output("spurious_done", 32'(out_done), 32'd0);
        end
        if (held) begin
          check_output("stall_data", out_data, held_data);
          check_output("stall_last", 32'(out_last), 32'(held_last));
          check_output("stall_valid", 32'(out_valid), 32'd1);
        end
        held = 1'b0;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_word: got 0x%0h expected no word", out_data);
          end else begin
            e = sb.pop_front();
            check_output("word_data", out_data, e.data);
            check_output("word_last", 32'(out_last), 32'(e.last));
            if (out_last) expect_done = 1'b1;
          end
          accepted++;
        end else if (out_valid) begin
          held = 1'b1;
          held_data = out_data;
          held_last = out_last;
        end
      end
    end
  end

  // Downstream ready: constant or the 1,0,0,1 backpressure pattern.
  initial begin
    int cyc;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      out_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [31:0] l0, input logic [31:0] l1);
    in_valid = v;
    in_data  = {l1, l0};
    tick();
  endtask

  task automatic idle();
    in_valid = '0;
    in_data  = '0;
  endtask

  task automatic push_word(input logic [31:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    sb.push_back(e);
  endtask

  task automatic apply_stimulus(input logic [31:0] base, input bit with_overflow);
    for (int k = 0; k < 4; k++)
      for (int p = 0; p < 4; p++)
        push_word(base + 32'(16 * k + p), (k == 3) && (p == 3));
    for (int p = 0; p < 4; p++) drive(4'b0011, base + 32'(p), base + 32'(16 + p));
    if (with_overflow) drive(4'b0001, 32'hDEAD, 32'h0);
    for (int p = 0; p < 4; p++) drive(4'b1100, base + 32'(32 + p), base + 32'(48 + p));
    idle();
  endtask

  task automatic wait_done(input string name);
    int start;
    int n;
    start = done_count;
    n = 0;
    while (done_count == start && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (done_count == start) begin
      failures++;
      $display("[TB] FAIL %s: got no out_done expected one within 300 cycles", name);
    end
  endtask

  task automatic do_reset();
    res_n = 1'b0;
    idle();
    tick();
    tick();
    res_n = 1'b1;
    tick();
  endtask

  initial begin
    int n;
    int start;
    res_n = 1'b0;
    tick();
    tick();
    check_output("rst_in_ready", 32'(in_ready), 32'd1);
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_out_data", out_data, 32'd0);
    check_output("rst_out_last", 32'(out_last), 32'd0);
    check_output("rst_out_done", 32'(out_done), 32'd0);
    check_output("rst_err", 32'(err), 32'd0);
    res_n = 1'b1;
    tick();

    $display("[TB] nominal frame");
    apply_stimulus(32'h0, 1'b0);
    wait_done("nominal_done");
    check_output("nominal_err", 32'(err), 32'd0);
    check_output("nominal_in_ready", 32'(in_ready), 32'd1);
    check_output("nominal_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] backpressure frame");
    rdy_mode = 1;
    apply_stimulus(32'h0, 1'b0);
    wait_done("bp_done");
    rdy_mode = 0;
    check_output("bp_sb_empty", 32'(sb.size()), 32'd0);
    check_output("bp_err", 32'(err), 32'd0);

    $display("[TB] lane conflict");
    drive(4'b0101, 32'hAA, 32'h0);
    check_output("conflict_err", 32'(err), 32'd1);
    push_word(32'hAA, 1'b0);
    for (int p = 1; p < 4; p++) push_word(32'(p), 1'b0);
    for (int k = 1; k < 4; k++)
      for (int p = 0; p < 4; p++)
        push_word(32'(16 * k + p), (k == 3) && (p == 3));
    for (int p = 1; p < 4; p++) drive(4'b0001, 32'(p), 32'h0);
    for (int p = 0; p < 4; p++) drive(4'b0010, 32'h0, 32'(16 + p));
    for (int p = 0; p < 4; p++) drive(4'b1100, 32'(32 + p), 32'(48 + p));
    idle();
    wait_done("conflict_done");
    check_output("conflict_err_sticky", 32'(err), 32'd1);
    check_output("conflict_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] overflow and stream-time input");
    do_reset();
    check_output("ovf_err_cleared", 32'(err), 32'd0);
    apply_stimulus(32'h0, 1'b1);
    check_output("ovf_err", 32'(err), 32'd1);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check_output("ovf_stream_started", 32'(out_valid), 32'd1);
    drive(4'b1111, 32'h55, 32'h66);
    idle();
    wait_done("ovf_done");
    check_output("ovf_err_sticky", 32'(err), 32'd1);
    check_output("ovf_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] reset mid-stream");
    do_reset();
    apply_stimulus(32'h100, 1'b0);
    start = accepted;
    n = 0;
    while ((accepted - start) < 6 && n < 100) begin
      tick();
      n++;
    end
    check_output("mid_words_accepted", 32'(accepted - start), 32'd6);
    res_n = 1'b0;
    #1;
    check_output("mid_rst_valid", 32'(out_valid), 32'd0);
    check_output("mid_rst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    tick();
    res_n = 1'b1;
    tick();
    apply_stimulus(32'h200, 1'b0);
    wait_done("mid_new_frame_done");
    check_output("mid_sb_empty", 32'(sb.size()), 32'd0);
    check_output("mid_err", 32'(err), 32'd0);

    $display("[TB] back-to-back frames");
    apply_stimulus(32'h300, 1'b0);
    n = 0;
    while (!out_done && n < 300) begin
      tick();
      n++;
    end
    check_output("b2b_first_done", 32'(out_done), 32'd1);
    apply_stimulus(32'h400, 1'b0);
    wait_done("b2b_second_done");
    check_output("b2b_sb_empty", 32'(sb.size()), 32'd0);
    check_output("b2b_err", 32'(err), 32'd0);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pooled_feature_collector.md
Name: pooled_feature_collector

Overview:
- Sits directly downstream of the conv/pooling layer.
- Captures pooled pixels from all NumberOfK kernels, which arrive on ProcessingElements shared lanes with one valid bit per kernel, into per-kernel feature-map banks.
- Once every map is complete, streams the flattened result (kernel-major, pixel-minor) one word per cycle under a valid/ready handshake, for the next dense or conv layer.

Parameters:
- BitSize, 32, width of one pixel word.
- ImageWidth, 4, width of the square convolution output feeding the pooling stage.
- Stride, 2, pooling stride. OutPixels = (ImageWidth/Stride)**2, default 4.
- NumberOfK, 4, number of kernels / feature maps.
- ProcessingElements, 2, number of shared data lanes. Kernel k always uses lane k % ProcessingElements.

Ports:
- clk  input  1  rising-edge clock.
- res_n  input  1  asynchronous active-low reset.
- in_valid  input  NumberOfK  bit k: the lane k%ProcessingElements word belongs to kernel k this cycle.
- in_data  input  ProcessingElements*BitSize  packed lanes, lane p at [p*BitSize +: BitSize].
- in_ready  output  1  high while in COLLECT; status only, upstream has no stall.
- out_valid  output  1  streamed word valid.
- out_ready  input  1  downstream accepts the word.
- out_data  output  BitSize  streamed word.
- out_last  output  1  high with the final word (kernel NumberOfK-1, pixel OutPixels-1).
- out_done  output  1  one-cycle pulse after the final word is accepted.
- err  output  1  sticky protocol-error flag; cleared only by reset.

Behaviour:
- Reset (async, res_n=0):
  - state=COLLECT; all per-kernel write counters, full flags and the read pointer cleared.
  - in_ready=1; out_valid=0, out_data=0, out_last=0, out_done=0, err=0.
  - Bank contents are not reset.
- Reset mid-operation aborts the frame immediately. Nothing partial is emitted after release.
- COLLECT state:
  - Each cycle, for every k with in_valid[k]=1 and full[k]=0: bank[k][wcnt[k]] <= lane(k%PE), then wcnt[k]++.
  - full[k] sets when wcnt[k] reaches OutPixels.
  - Up to ProcessingElements writes can occur per cycle.
- Lane conflict: two kernels sharing a lane both valid in the same cycle.
  - The lowest k is written; the others are dropped; err<=1.
- Overflow: in_valid[k] while full[k]=1 drops the word and sets err<=1.
- COLLECT -> STREAM on the edge after all full[] are 1.
  - On that same edge: out_valid<=1, out_data<=bank[0][0], rptr=0.
  - First out_valid is therefore 2 cycles after the cycle carrying the final input write.
- STREAM state:
  - in_ready=0. Any in_valid bit is dropped and sets err.
  - On out_valid & out_ready, rptr advances and the next word is registered. Zero bubbles under continuous out_ready, so 1 word/cycle.
  - Stall: while out_valid=1 and out_ready=0, out_data and out_last hold stable.
  - Word index i = k*OutPixels + p maps to bank[k][p]. out_last=1 when i = NumberOfK*OutPixels-1.
- Final word accepted:
  - Next edge: out_valid<=0, out_last<=0, out_done<=1 for exactly one cycle.
  - On the same edge: counters and full flags cleared, state=COLLECT, in_ready=1.
  - Inputs are accepted again from the cycle in which out_done is high.
- Arithmetic:
  - wcnt width is $clog2(OutPixels+1) and rptr width is $clog2(NumberOfK*OutPixels).
  - Counters never wrap: saturation and dropping are as above.

Decomposition:
- Package cnn_pkg holds:
  - state enum {COLLECT, STREAM};
  - a function out_pixels(ImageWidth, Stride);
  - a function lane_of(k, PE).
- One sub-module, feature_map_bank, instantiated per kernel:
  - OutPixels x BitSize register array with write counter and full flag;
  - write enable, write data and async read address as ports.
- The top module holds lane routing, conflict/err logic, the FSM and the output register.

Test Plan:
- Nominal frame (defaults): kernels 0/1 then 2/3 deliver values 16*k+p on their lanes, out_ready=1.
  - Expected: 16 consecutive words 0,1,2,3,16,17,...,51; out_last on 51; out_done one cycle later; err=0.
- Backpressure: same frame, out_ready toggled 1,0,0,1 repeating.
  - Expected: each word held stable while stalled; order and count unchanged; no duplicates.
- Lane conflict: in_valid=4'b0101 with lane0=0xAA.
  - Expected: bank0 gets 0xAA, kernel 2 counter unchanged, err=1 and stays 1.
- Overflow and stream-time input: a fifth in_valid[0] after kernel 0 is full, then an in_valid during STREAM.
  - Expected: both dropped, err=1, streamed data identical to the nominal frame.
- Reset mid-stream: res_n low after word 5 is accepted.
  - Expected: out_valid=0 and in_ready=1 immediately; a new full frame then streams correctly from word 0.
- Back-to-back frames: second frame's first inputs arrive in the out_done cycle.
  - Expected: they are captured, and the second stream matches the second frame's data.
